// File: rtl/ext_bus_pkg.sv
// Shared encodings for the external bus sequencer.
// Optional write acknowledge: define EXT_BUS_WRITE_ACK_EN.
package ext_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_LO = 2'd1,
        ADDR_HI = 2'd2,
        DATA    = 2'd3
    } state_t;

    localparam logic SPACE_ROM  = 1'b0;
    localparam logic SPACE_RAM  = 1'b1;
    localparam logic PHASE_ADDR = 1'b0;
    localparam logic PHASE_DATA = 1'b1;
    localparam int   WAIT_W     = 4;

    function automatic logic [7:0] data_byte(input logic write, input logic [7:0] wdata);
        return write ? wdata : 8'h00;
    endfunction

endpackage

// File: rtl/ext_bus_ctrl.sv
// Serializes one core read/write into address and data phases on 8-bit pins.
// Define EXT_BUS_WRITE_ACK_EN to also pulse rsp_valid on write completion.
module ext_bus_ctrl
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_space,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    input  logic [7:0]        bus_in,
    output logic [7:0]        bus_out,
    output logic              rom_ram,
    output logic              addr_data,
    output logic              bus_we
);

    state_t            state_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [7:0]        rdata_q;
    logic [7:0]        bus_out_q;
    logic              rom_ram_q;
    logic              addr_data_q;
    logic              bus_we_q;
    logic              write_q;
    logic [15:0]       addr_q;
    logic [7:0]        wdata_q;
    logic [WAIT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            bus_out_q   <= 8'h00;
            rom_ram_q   <= SPACE_ROM;
            addr_data_q <= PHASE_ADDR;
            bus_we_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        state_q   <= ADDR_LO;
                        ready_q   <= 1'b0;
                        write_q   <= req_write;
                        addr_q    <= 16'(req_addr);
                        wdata_q   <= req_wdata;
                        bus_out_q <= req_addr[7:0];
                        rom_ram_q <= req_space;
                        bus_we_q  <= req_write;
                    end
                end
                ADDR_LO: begin
                    if (ADDR_W == 16) begin
                        state_q   <= ADDR_HI;
                        bus_out_q <= addr_q[15:8];
                    end else begin
                        state_q     <= DATA;
                        addr_data_q <= PHASE_DATA;
                        bus_out_q   <= data_byte(write_q, wdata_q);
                        cnt_q       <= WAIT_W'(WAIT_CYCLES);
                    end
                end
                ADDR_HI: begin
                    state_q     <= DATA;
                    addr_data_q <= PHASE_DATA;
                    bus_out_q   <= data_byte(write_q, wdata_q);
                    cnt_q       <= WAIT_W'(WAIT_CYCLES);
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        bus_out_q   <= 8'h00;
                        rom_ram_q   <= SPACE_ROM;
                        addr_data_q <= PHASE_ADDR;
                        bus_we_q    <= 1'b0;
                        if (!write_q) begin
                            rdata_q <= bus_in;
                        end
`ifdef EXT_BUS_WRITE_ACK_EN
                        rsp_valid_q <= 1'b1;
`else
                        rsp_valid_q <= !write_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign bus_out   = bus_out_q;
    assign rom_ram   = rom_ram_q;
    assign addr_data = addr_data_q;
    assign bus_we    = bus_we_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl: default, 16-bit address and zero-wait builds.
// Honors EXT_BUS_WRITE_ACK_EN for the expected write response.
module tb_ext_bus_ctrl;

`ifdef EXT_BUS_WRITE_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       req_write = 1'b0;
    logic       req_space = 1'b0;
    logic [7:0] req_wdata = 8'h00;
    logic [7:0] bus_in = 8'h00;

    logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [7:0]  a0 = 8'h00, a2 = 8'h00;
    logic [15:0] a1 = 16'h0000;

    logic       r0, rv0, rr0, ad0, we0;
    logic       r1, rv1, rr1, ad1, we1;
    logic       r2, rv2, rr2, ad2, we2;
    logic [7:0] rd0, bo0, rd1, bo1, rd2, bo2;

    ext_bus_ctrl #(.ADDR_W(8), .WAIT_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0),
        .req_write(req_write), .req_space(req_space), .req_addr(a0),
        .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0),
        .bus_in(bus_in), .bus_out(bo0), .rom_ram(rr0),
        .addr_data(ad0), .bus_we(we0)
    );

    ext_bus_ctrl #(.ADDR_W(16), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1),
        .req_write(req_write), .req_space(req_space), .req_addr(a1),
        .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
        .bus_in(bus_in), .bus_out(bo1), .rom_ram(rr1),
        .addr_data(ad1), .bus_we(we1)
    );

    ext_bus_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(r2),
        .req_write(req_write), .req_space(req_space), .req_addr(a2),
        .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_rdata(rd2),
        .bus_in(bus_in), .bus_out(bo2), .rom_ram(rr2),
        .addr_data(ad2), .bus_we(we2)
    );

    // Observed bundle: {ready, rsp_valid, addr_data, rom_ram, bus_we, bus_out}
    logic [12:0] o0, o1, o2;
    assign o0 = {r0, rv0, ad0, rr0, we0, bo0};
    assign o1 = {r1, rv1, ad1, rr1, we1, bo1};
    assign o2 = {r2, rv2, ad2, rr2, we2, bo2};

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [12:0] ex(input logic rdy, input logic rsp,
                                       input logic ad, input logic rr,
                                       input logic we, input logic [7:0] bo);
        return {rdy, rsp, ad, rr, we, bo};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (o0 !== ex(1, 0, 0, 0, 0, 8'h00) || rd0 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_u0 got %h/%h want %h/00", o0, rd0, ex(1, 0, 0, 0, 0, 8'h00));
        end
        vectors++;
        if (o1 !== ex(1, 0, 0, 0, 0, 8'h00) || rd1 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_u1 got %h/%h want %h/00", o1, rd1, ex(1, 0, 0, 0, 0, 8'h00));
        end
        vectors++;
        if (o2 !== ex(1, 0, 0, 0, 0, 8'h00) || rd2 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_u2 got %h/%h want %h/00", o2, rd2, ex(1, 0, 0, 0, 0, 8'h00));
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_default();
        logic [12:0] e [5];
        e[0] = ex(0, 0, 0, 0, 0, 8'h3C);
        e[1] = ex(0, 0, 1, 0, 0, 8'h00);
        e[2] = ex(0, 0, 1, 0, 0, 8'h00);
        e[3] = ex(1, 1, 0, 0, 0, 8'h00);
        e[4] = ex(1, 0, 0, 0, 0, 8'h00);
        a0 = 8'h3C; req_space = 1'b0; req_write = 1'b0; bus_in = 8'hA5; v0 = 1'b1;
        step();
        v0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            vectors++;
            if (o0 !== e[i]) begin
                miscompares++;
                $display("FAIL read_default cyc%0d got %h want %h", i + 1, o0, e[i]);
            end
        end
        vectors++;
        if (rd0 !== 8'hA5) begin
            miscompares++;
            $display("FAIL read_default_rdata got %h want a5", rd0);
        end
    endtask

    task automatic test_write16();
        logic [12:0] e [6];
        e[0] = ex(0, 0, 0, 1, 1, 8'hF0);
        e[1] = ex(0, 0, 0, 1, 1, 8'h12);
        e[2] = ex(0, 0, 1, 1, 1, 8'h5A);
        e[3] = ex(0, 0, 1, 1, 1, 8'h5A);
        e[4] = ex(1, ACK, 0, 0, 0, 8'h00);
        e[5] = ex(1, 0, 0, 0, 0, 8'h00);
        a1 = 16'h12F0; req_space = 1'b1; req_write = 1'b1; req_wdata = 8'h5A;
        bus_in = 8'hEE; v1 = 1'b1;
        step();
        v1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            vectors++;
            if (o1 !== e[i]) begin
                miscompares++;
                $display("FAIL write16 cyc%0d got %h want %h", i + 1, o1, e[i]);
            end
        end
        vectors++;
        if (rd1 !== 8'h00) begin
            miscompares++;
            $display("FAIL write16_rdata got %h want 00", rd1);
        end
        req_space = 1'b0; req_write = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] e [8];
        e[0] = ex(0, 0, 0, 0, 0, 8'h11);
        e[1] = ex(0, 0, 1, 0, 0, 8'h00);
        e[2] = ex(0, 0, 1, 0, 0, 8'h00);
        e[3] = ex(1, 1, 0, 0, 0, 8'h00);
        e[4] = ex(0, 0, 0, 0, 0, 8'h33);
        e[5] = ex(0, 0, 1, 0, 0, 8'h00);
        e[6] = ex(0, 0, 1, 0, 0, 8'h00);
        e[7] = ex(1, 1, 0, 0, 0, 8'h00);
        a0 = 8'h11; bus_in = 8'h22; v0 = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            vectors++;
            if (o0 !== e[i]) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d got %h want %h", i + 1, o0, e[i]);
            end
            if (i == 0) a0 = 8'h33;
            if (i == 3) begin
                vectors++;
                if (rd0 !== 8'h22) begin
                    miscompares++;
                    $display("FAIL b2b_rdata1 got %h want 22", rd0);
                end
            end
            if (i == 4) begin
                v0 = 1'b0;
                bus_in = 8'h44;
            end
        end
        vectors++;
        if (rd0 !== 8'h44) begin
            miscompares++;
            $display("FAIL b2b_rdata2 got %h want 44", rd0);
        end
        step();
    endtask

    task automatic test_busy_ignore();
        logic [12:0] e [7];
        e[0] = ex(0, 0, 0, 0, 0, 8'h5A);
        e[1] = ex(0, 0, 0, 0, 0, 8'h3C);
        e[2] = ex(0, 0, 1, 0, 0, 8'h00);
        e[3] = ex(0, 0, 1, 0, 0, 8'h00);
        e[4] = ex(1, 1, 0, 0, 0, 8'h00);
        e[5] = ex(1, 0, 0, 0, 0, 8'h00);
        e[6] = ex(1, 0, 0, 0, 0, 8'h00);
        a1 = 16'h3C5A; bus_in = 8'hC3; v1 = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            vectors++;
            if (o1 !== e[i]) begin
                miscompares++;
                $display("FAIL busy_ignore cyc%0d got %h want %h", i + 1, o1, e[i]);
            end
            if (i == 0) a1 = 16'hFFFF;
            if (i == 1) v1 = 1'b0;
        end
        vectors++;
        if (rd1 !== 8'hC3) begin
            miscompares++;
            $display("FAIL busy_ignore_rdata got %h want c3", rd1);
        end
    endtask

    task automatic test_reset_midop();
        logic [12:0] e [4];
        a0 = 8'h55; bus_in = 8'h66; v0 = 1'b1;
        step();
        v0 = 1'b0;
        step();
        vectors++;
        if (o0 !== ex(0, 0, 1, 0, 0, 8'h00)) begin
            miscompares++;
            $display("FAIL midop_data got %h want %h", o0, ex(0, 0, 1, 0, 0, 8'h00));
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (o0 !== ex(1, 0, 0, 0, 0, 8'h00) || rd0 !== 8'h00) begin
            miscompares++;
            $display("FAIL midop_async got %h/%h want %h/00", o0, rd0, ex(1, 0, 0, 0, 0, 8'h00));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (o0 !== ex(1, 0, 0, 0, 0, 8'h00)) begin
                miscompares++;
                $display("FAIL midop_hold cyc%0d got %h want %h", i, o0, ex(1, 0, 0, 0, 0, 8'h00));
            end
        end
        rst_n = 1'b1;
        step();
        e[0] = ex(0, 0, 0, 0, 0, 8'h01);
        e[1] = ex(0, 0, 1, 0, 0, 8'h00);
        e[2] = ex(0, 0, 1, 0, 0, 8'h00);
        e[3] = ex(1, 1, 0, 0, 0, 8'h00);
        a0 = 8'h01; bus_in = 8'h99; v0 = 1'b1;
        step();
        v0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            vectors++;
            if (o0 !== e[i]) begin
                miscompares++;
                $display("FAIL post_reset_read cyc%0d got %h want %h", i + 1, o0, e[i]);
            end
        end
        vectors++;
        if (rd0 !== 8'h99) begin
            miscompares++;
            $display("FAIL post_reset_rdata got %h want 99", rd0);
        end
    endtask

    task automatic test_wait0();
        logic [12:0] e [4];
        e[0] = ex(0, 0, 0, 0, 0, 8'h01);
        e[1] = ex(0, 0, 1, 0, 0, 8'h00);
        e[2] = ex(1, 1, 0, 0, 0, 8'h00);
        e[3] = ex(1, 0, 0, 0, 0, 8'h00);
        a2 = 8'h01; bus_in = 8'h7E; v2 = 1'b1;
        step();
        v2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            vectors++;
            if (o2 !== e[i]) begin
                miscompares++;
                $display("FAIL wait0 cyc%0d got %h want %h", i + 1, o2, e[i]);
            end
        end
        vectors++;
        if (rd2 !== 8'h7E) begin
            miscompares++;
            $display("FAIL wait0_rdata got %h want 7e", rd2);
        end
    endtask

    initial begin
        test_reset();
        test_read_default();
        test_write16();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midop();
        test_wait0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
